// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_arb_pkg                                                     |
// | Shared types and constants for the FIFO write-port arbiter.      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_SETTLE = 2'd2
  } arb_state_e;

  localparam int c_SETTLE_DEFAULT = 3;
  localparam int c_NREQ_MIN       = 2;
  localparam int c_NREQ_MAX       = 16;

endpackage
`default_nettype wire

// File: rtl/arb_rr_pick.sv
`default_nettype none
// +------------------------------------------------------------------+
// | arb_rr_pick                                                      |
// | Combinational winner select: round-robin from a pointer, or      |
// | lowest-index-wins when FIFO_WR_ARBITER_FIXED_PRIO_EN is defined. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module arb_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
`ifndef FIFO_WR_ARBITER_FIXED_PRIO_EN
  input  logic [IDXW-1:0] i_ptr,
`endif
  output logic [NREQ-1:0] o_onehot,
  output logic [IDXW-1:0] o_idx
);

  logic [NREQ-1:0] w_mask;
  int              w_pos;

  // Candidates are visited from lowest to highest priority so the last hit wins.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    w_mask   = '0;
    w_pos    = 0;
`ifdef FIFO_WR_ARBITER_FIXED_PRIO_EN
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_pos  = k;
      w_mask = NREQ'(1) << w_pos;
      if ((i_req & w_mask) != '0) begin
        o_onehot = w_mask;
        o_idx    = IDXW'(w_pos);
      end
    end
`else
    for (int k = NREQ; k >= 1; k--) begin
      w_pos  = (int'(i_ptr) + k) % NREQ;
      w_mask = NREQ'(1) << w_pos;
      if ((i_req & w_mask) != '0) begin
        o_onehot = w_mask;
        o_idx    = IDXW'(w_pos);
      end
    end
`endif
  end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_wr_arbiter                                                  |
// | Shares one FIFO write port among NREQ producers; one strobe per  |
// | grant followed by a SETTLE-cycle quiet window.                   |
// | Option: FIFO_WR_ARBITER_FIXED_PRIO_EN selects fixed priority.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int dbits  = 8,
  parameter int SETTLE = c_SETTLE_DEFAULT
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*dbits-1:0]   req_data,
  input  logic                    fifo_full,
  output logic [NREQ-1:0]         ack,
  output logic                    fifo_wr,
  output logic [dbits-1:0]        fifo_din,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy
);

  localparam int c_IDXW = $clog2(NREQ);
  localparam int c_CW   = $clog2(SETTLE + 1);

  arb_state_e        r_state, w_state_nxt;
  logic [c_CW-1:0]   r_cnt, w_cnt_nxt;
  logic [NREQ-1:0]   r_ack, w_ack_nxt;
  logic              r_wr, w_wr_nxt;
  logic [dbits-1:0]  r_din, w_din_nxt;
  logic [c_IDXW-1:0] r_gid, w_gid_nxt;
  logic              w_grant;
  logic [NREQ-1:0]   w_win_oh;
  logic [c_IDXW-1:0] w_win_idx;

`ifdef FIFO_WR_ARBITER_FIXED_PRIO_EN
  arb_rr_pick #(.NREQ(NREQ), .IDXW(c_IDXW)) u_pick (
    .i_req    (req),
    .o_onehot (w_win_oh),
    .o_idx    (w_win_idx)
  );
`else
  logic [c_IDXW-1:0] r_ptr;

  // Pointer starts at NREQ-1 so requester 0 is scanned first after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr <= c_IDXW'(NREQ - 1);
    end else if (w_grant) begin
      r_ptr <= w_win_idx;
    end
  end

  arb_rr_pick #(.NREQ(NREQ), .IDXW(c_IDXW)) u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_onehot (w_win_oh),
    .o_idx    (w_win_idx)
  );
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ack   <= '0;
      r_wr    <= 1'b0;
      r_din   <= '0;
      r_gid   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ack   <= w_ack_nxt;
      r_wr    <= w_wr_nxt;
      r_din   <= w_din_nxt;
      r_gid   <= w_gid_nxt;
    end
  end

  // ack and fifo_wr are registered at the grant so both are high during STROBE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ack_nxt   = '0;
    w_wr_nxt    = 1'b0;
    w_din_nxt   = r_din;
    w_gid_nxt   = r_gid;
    w_grant     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if ((|req) && !fifo_full) begin
          w_grant     = 1'b1;
          w_ack_nxt   = w_win_oh;
          w_wr_nxt    = 1'b1;
          w_din_nxt   = req_data[int'(w_win_idx)*dbits +: dbits];
          w_gid_nxt   = w_win_idx;
          w_state_nxt = ST_STROBE;
        end
      end
      ST_STROBE: begin
        w_cnt_nxt   = c_CW'(SETTLE);
        w_state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        w_cnt_nxt = r_cnt - c_CW'(1);
        if (r_cnt <= c_CW'(1)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign ack      = r_ack;
  assign fifo_wr  = r_wr;
  assign fifo_din = r_din;
  assign grant_id = r_gid;
  assign busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fifo_wr_arbiter                                               |
// | Directed scenarios plus randomized traffic against a             |
// | grant-level reference model of the write-port arbiter.           |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_fifo_wr_arbiter;

  localparam int NREQ   = 4;
  localparam int DBITS  = 8;
  localparam int SETTLE = 3;

  logic        clock;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        fifo_full;
  logic [3:0]  ack;
  logic        fifo_wr;
  logic [7:0]  fifo_din;
  logic [1:0]  grant_id;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_wr_arbiter #(.NREQ(NREQ), .dbits(DBITS), .SETTLE(SETTLE)) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .fifo_full(fifo_full),
    .ack      (ack),
    .fifo_wr  (fifo_wr),
    .fifo_din (fifo_din),
    .grant_id (grant_id),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; req = '0; fifo_full = 1'b0;
    tick; tick;
    reset = 1'b0;
  endtask

  // Reference winner: first requester after the last winner (or lowest index when fixed).
  function automatic int model_pick(logic [3:0] r, int last);
`ifdef FIFO_WR_ARBITER_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++)
      if (((r >> i) & 4'b0001) != 4'b0000) return i;
`else
    for (int k = 1; k <= 4; k++)
      if (((r >> ((last + k) % 4)) & 4'b0001) != 4'b0000) return (last + k) % 4;
`endif
    return -1;
  endfunction

  task automatic test_reset;
    reset = 1'b1; req = 4'b1111; fifo_full = 1'b0; req_data = 32'hDEADBEEF;
    tick; tick;
    n_tests++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack got %b want %b", ack, 4'b0000); end
    n_tests++; if (fifo_wr !== 1'b0) begin n_fail++; $display("FAIL reset_wr got %b want 0", fifo_wr); end
    n_tests++; if (fifo_din !== 8'h00) begin n_fail++; $display("FAIL reset_din got %h want 00", fifo_din); end
    n_tests++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_gid got %0d want 0", grant_id); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    reset = 1'b0; req = '0;
  endtask

  task automatic test_single;
    do_reset;
    req_data = $urandom; req_data[23:16] = 8'hA5; req = 4'b0100;
    tick;
    n_tests++; if (ack !== 4'b0100) begin n_fail++; $display("FAIL single_ack got %b want 0100", ack); end
    n_tests++; if (fifo_wr !== 1'b1) begin n_fail++; $display("FAIL single_wr got %b want 1", fifo_wr); end
    n_tests++; if (fifo_din !== 8'hA5) begin n_fail++; $display("FAIL single_din got %h want a5", fifo_din); end
    n_tests++; if (grant_id !== 2'd2) begin n_fail++; $display("FAIL single_gid got %0d want 2", grant_id); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b want 1", busy); end
    req = 4'b0000;
    for (int c = 2; c <= 1 + SETTLE; c++) begin
      tick;
      n_tests++;
      if ({ack, fifo_wr, busy} !== {4'b0000, 1'b0, 1'b1}) begin
        n_fail++; $display("FAIL single_settle c=%0d got ack=%b wr=%b busy=%b want 0000/0/1", c, ack, fifo_wr, busy);
      end
    end
    tick;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy got %b want 0", busy); end
    req = 4'b0001; req_data[7:0] = 8'h3C;
    tick;
    n_tests++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL single_next_ack got %b want 0001", ack); end
    n_tests++; if (fifo_din !== 8'h3C) begin n_fail++; $display("FAIL single_next_din got %h want 3c", fifo_din); end
    req = 4'b0000;
  endtask

  task automatic run_grants(input logic [3:0] r, input int exp_seq[5], input string name);
    int k = 0;
    int last_c = 0;
    do_reset;
    req_data = {8'd3, 8'd2, 8'd1, 8'd0}; req = r;
    for (int c = 1; c <= 40 && k < 5; c++) begin
      tick;
      if (fifo_wr === 1'b1) begin
        n_tests++;
        if (grant_id !== 2'(exp_seq[k]) || fifo_din !== 8'(exp_seq[k]) || ack !== (4'b0001 << exp_seq[k])) begin
          n_fail++; $display("FAIL %s_grant%0d got id=%0d din=%0d ack=%b want id=%0d", name, k, grant_id, fifo_din, ack, exp_seq[k]);
        end
        n_tests++;
        if ((c - last_c) !== ((k == 0) ? 1 : SETTLE + 2)) begin
          n_fail++; $display("FAIL %s_spacing%0d got %0d want %0d", name, k, c - last_c, (k == 0) ? 1 : SETTLE + 2);
        end
        last_c = c; k++;
      end
    end
    n_tests++; if (k != 5) begin n_fail++; $display("FAIL %s_count got %0d want 5", name, k); end
    req = 4'b0000;
  endtask

  task automatic test_round_robin;
    int seq[5] = '{0, 1, 2, 3, 0};
    run_grants(4'b1111, seq, "rr_all");
  endtask

  task automatic test_prio_pattern;
`ifdef FIFO_WR_ARBITER_FIXED_PRIO_EN
    int seq[5] = '{0, 0, 0, 0, 0};
`else
    int seq[5] = '{0, 3, 0, 3, 0};
`endif
    run_grants(4'b1001, seq, "pair_1001");
  endtask

  task automatic test_full_stall;
    do_reset;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11}; fifo_full = 1'b1; req = 4'b0011;
    for (int c = 0; c < 20; c++) begin
      tick;
      n_tests++;
      if (ack !== 4'b0000 || fifo_wr !== 1'b0) begin
        n_fail++; $display("FAIL full_stall c=%0d got ack=%b wr=%b want 0000/0", c, ack, fifo_wr);
      end
    end
    fifo_full = 1'b0;
    tick;
    n_tests++; if (ack !== 4'b0001 || fifo_din !== 8'h11) begin n_fail++; $display("FAIL full_release0 got ack=%b din=%h want 0001/11", ack, fifo_din); end
    req = 4'b0010;
    repeat (SETTLE + 1) tick;
    tick;
    n_tests++; if (ack !== 4'b0010 || grant_id !== 2'd1) begin n_fail++; $display("FAIL full_release1 got ack=%b id=%0d want 0010/1", ack, grant_id); end
    req = 4'b0000;
  endtask

  task automatic test_full_in_settle;
    do_reset;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11}; req = 4'b0001;
    tick;
    req = 4'b0010;
    tick;
    fifo_full = 1'b1;
    tick;
    n_tests++; if (busy !== 1'b1 || fifo_wr !== 1'b0) begin n_fail++; $display("FAIL settle_full_a got busy=%b wr=%b want 1/0", busy, fifo_wr); end
    tick;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL settle_full_b got busy=%b want 1", busy); end
    tick;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL settle_full_idle got busy=%b want 0", busy); end
    for (int c = 0; c < 10; c++) begin
      tick;
      n_tests++;
      if (ack !== 4'b0000 || fifo_wr !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL settle_full_stall c=%0d got ack=%b wr=%b busy=%b want 0000/0/0", c, ack, fifo_wr, busy);
      end
    end
    fifo_full = 1'b0;
    tick;
    n_tests++; if (ack !== 4'b0010 || fifo_din !== 8'h22) begin n_fail++; $display("FAIL settle_full_resume got ack=%b din=%h want 0010/22", ack, fifo_din); end
    req = 4'b0000;
  endtask

  task automatic test_reset_mid_strobe;
    do_reset;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11}; req = 4'b0100;
    tick;
    n_tests++; if (fifo_wr !== 1'b1) begin n_fail++; $display("FAIL midrst_strobe got wr=%b want 1", fifo_wr); end
    reset = 1'b1; req = 4'b0000;
    tick;
    n_tests++;
    if ({ack, fifo_wr, fifo_din, grant_id, busy} !== 16'h0000) begin
      n_fail++; $display("FAIL midrst_outputs got ack=%b wr=%b din=%h id=%0d busy=%b want all 0", ack, fifo_wr, fifo_din, grant_id, busy);
    end
    reset = 1'b0; req = 4'b1111; req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    tick;
    n_tests++; if (ack !== 4'b0001 || grant_id !== 2'd0 || fifo_din !== 8'h10) begin n_fail++; $display("FAIL midrst_first got ack=%b id=%0d din=%h want 0001/0/10", ack, grant_id, fifo_din); end
    req = 4'b0000;
  endtask

  task automatic test_random;
    int         m_last = 3;
    int         m_busy_left = 0;
    logic [3:0] m_ack;
    logic       m_wr;
    logic [7:0] m_din = 8'h00;
    logic [1:0] m_gid = 2'd0;
    int         w;
    do_reset;
    for (int c = 0; c < 500; c++) begin
      @(posedge clock);
      m_ack = 4'b0000; m_wr = 1'b0;
      if (m_busy_left == 0) begin
        if (req != 4'b0000 && !fifo_full) begin
          w = model_pick(req, m_last);
          m_ack = 4'b0001 << w; m_wr = 1'b1;
          m_din = req_data[w*8 +: 8]; m_gid = 2'(w);
          m_last = w; m_busy_left = SETTLE + 1;
        end
      end else begin
        m_busy_left--;
      end
      #1;
      n_tests++; if (ack !== m_ack) begin n_fail++; $display("FAIL rand_ack c=%0d got %b want %b", c, ack, m_ack); end
      n_tests++; if (fifo_wr !== m_wr) begin n_fail++; $display("FAIL rand_wr c=%0d got %b want %b", c, fifo_wr, m_wr); end
      n_tests++; if (fifo_din !== m_din) begin n_fail++; $display("FAIL rand_din c=%0d got %h want %h", c, fifo_din, m_din); end
      n_tests++; if (grant_id !== m_gid) begin n_fail++; $display("FAIL rand_gid c=%0d got %0d want %0d", c, grant_id, m_gid); end
      n_tests++; if (busy !== (m_busy_left != 0)) begin n_fail++; $display("FAIL rand_busy c=%0d got %b want %b", c, busy, m_busy_left != 0); end
      // Requesters hold until acked, occasionally withdraw, and may re-request later.
      for (int i = 0; i < 4; i++) begin
        if (m_ack[i]) begin
          req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(0, 99) < 35) begin
            req[i] = 1'b1; req_data[i*8 +: 8] = 8'($urandom);
          end
        end else if ($urandom_range(0, 99) < 4) begin
          req[i] = 1'b0;
        end
      end
      fifo_full = ($urandom_range(0, 4) == 0);
    end
    req = 4'b0000; fifo_full = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req = '0; req_data = '0; fifo_full = 1'b0;
    test_reset;
    test_single;
    test_round_robin;
    test_prio_pattern;
    test_full_stall;
    test_full_in_settle;
    test_reset_mid_strobe;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
